// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl
// Time-multiplexed scan controller for a 4-digit seven-segment display.
// Each digit slot lasts DIV cycles: GUARD cycles with every anode off so the
// segment multiplexer can settle, then DIV-GUARD cycles with the selected
// digit lit (unless that digit is blanked). A one-cycle frame pulse marks
// the wrap from digit 3 back to digit 0.
//
// Ports:
//   clk    system clock, rising edge
//   rst    synchronous active-high reset
//   en     scan enable; low forces the display dark and returns to digit 0
//   blank  per-digit blanking, bit i blanks digit i, sampled once per slot
//   sel    registered digit select for the segment multiplexer
//   an     registered active-low anode enables, an[i] drives digit i
//   frame  one-cycle pulse on the cycle sel has just wrapped from 3 to 0
module seg_scan_ctrl #(
  parameter int DIV   = 100000,
  parameter int GUARD = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [3:0] blank,
  output logic [1:0] sel,
  output logic [3:0] an,
  output logic       frame
);

  localparam int CW = $clog2(DIV);
  localparam logic [CW-1:0] CNT_LAST   = CW'(DIV - 1);
  localparam logic [CW-1:0] GUARD_LAST = CW'(GUARD - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_GUARD,
    S_ON
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          blank_q;

  // Single registered FSM. The slot counter spans the whole slot (guard and
  // lit part); the lit anode pattern is loaded on the same edge that enters
  // ON so the anode turns on exactly GUARD cycles into the slot. Leaving ON
  // loads an all-off pattern on the same edge that advances sel, so an
  // anode is never low while sel is changing.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      cnt     <= '0;
      sel     <= 2'd0;
      an      <= 4'hF;
      frame   <= 1'b0;
      blank_q <= 1'b0;
    end else begin
      frame <= 1'b0;
      case (state)
        S_IDLE: begin
          cnt <= '0;
          sel <= 2'd0;
          an  <= 4'hF;
          if (en) begin
            state <= S_GUARD;
          end
        end

        S_GUARD: begin
          if (!en) begin
            state <= S_IDLE;
            cnt   <= '0;
            sel   <= 2'd0;
            an    <= 4'hF;
          end else begin
            cnt <= cnt + 1'b1;
            an  <= 4'hF;
            if (cnt == GUARD_LAST) begin
              // Blank is captured here only; mid-slot changes wait a slot.
              state   <= S_ON;
              blank_q <= blank[sel];
              an      <= blank[sel] ? 4'hF : ~(4'b0001 << sel);
            end
          end
        end

        S_ON: begin
          if (!en) begin
            state <= S_IDLE;
            cnt   <= '0;
            sel   <= 2'd0;
            an    <= 4'hF;
          end else if (cnt == CNT_LAST) begin
            state <= S_GUARD;
            cnt   <= '0;
            sel   <= sel + 2'd1;
            an    <= 4'hF;
            frame <= (sel == 2'd3);
          end else begin
            cnt <= cnt + 1'b1;
            an  <= blank_q ? 4'hF : ~(4'b0001 << sel);
          end
        end

        default: begin
          state <= S_IDLE;
          cnt   <= '0;
          sel   <= 2'd0;
          an    <= 4'hF;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl
// Self-checking bench for seg_scan_ctrl with DIV=8, GUARD=2. The reference
// model tracks only "cycles since the scan started" and derives digit, lit
// phase and frame pulse arithmetically from that count.
module tb_seg_scan_ctrl;

  localparam int DIV   = 8;
  localparam int GUARD = 2;
  localparam int FRAME = 4 * DIV;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [3:0] blank;
  logic [1:0] sel;
  logic [3:0] an;
  logic       frame;

  int vectors    = 0;
  int miscompares = 0;
  int cyc        = 0;

  // reference model state
  bit         m_active  = 1'b0;
  int         m_t       = 0;
  bit [3:0]   m_latched = 4'b0000;

  // invariant tracking
  logic [1:0] prev_sel  = 2'd0;
  bit         fvalid    = 1'b0;
  int         flast     = 0;

  logic [3:0] cur_blank = 4'b0000;

  typedef struct {
    logic       rst;
    logic       en;
    logic [3:0] blank;
    logic [1:0] sel;
    logic [3:0] an;
    logic       frame;
  } vec_t;

  vec_t tbl[13];

  seg_scan_ctrl #(.DIV(DIV), .GUARD(GUARD)) dut (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .blank (blank),
    .sel   (sel),
    .an    (an),
    .frame (frame)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [1:0] es,
                             input logic [3:0] ea, input logic ef);
    vectors++;
    if (sel !== es || an !== ea || frame !== ef) begin
      miscompares++;
      $display("[TB] FAIL %s cyc=%0d: got sel=%b an=%b frame=%b, expected sel=%b an=%b frame=%b",
               name, cyc, sel, an, frame, es, ea, ef);
    end
  endtask

  task automatic checkInvariants();
    vectors++;
    if ($countones(~an) > 1) begin
      miscompares++;
      $display("[TB] FAIL one_hot_an cyc=%0d: got an=%b, expected at most one low bit", cyc, an);
    end
    if (sel !== prev_sel) begin
      vectors++;
      if (an !== 4'hF) begin
        miscompares++;
        $display("[TB] FAIL dark_on_sel_change cyc=%0d: got an=%b, expected 1111", cyc, an);
      end
    end
    prev_sel = sel;
    if (!m_active) begin
      fvalid = 1'b0;
    end else if (frame === 1'b1) begin
      if (fvalid) begin
        vectors++;
        if (cyc - flast != FRAME) begin
          miscompares++;
          $display("[TB] FAIL frame_spacing cyc=%0d: got %0d cycles, expected %0d",
                   cyc, cyc - flast, FRAME);
        end
      end
      fvalid = 1'b1;
      flast  = cyc;
    end
  endtask

  // Drive inputs, clock once, advance the model and compare against it.
  task automatic applyStimulus(input logic r, input logic e, input logic [3:0] b);
    int         p;
    int         slot;
    logic [1:0] es;
    logic [3:0] ea;
    logic       ef;
    rst   = r;
    en    = e;
    blank = b;
    @(posedge clk);
    if (r) begin
      m_active = 1'b0;
      m_t      = 0;
    end else if (!e) begin
      m_active = 1'b0;
    end else if (!m_active) begin
      m_active = 1'b1;
      m_t      = 0;
    end else begin
      // the last guard cycle's edge captures the blank bit of this slot
      if (m_t % DIV == GUARD - 1) begin
        slot = (m_t % FRAME) / DIV;
        m_latched[slot] = b[slot];
      end
      m_t++;
    end
    cyc++;
    #1;
    if (!m_active) begin
      es = 2'd0;
      ea = 4'hF;
      ef = 1'b0;
    end else begin
      p    = m_t % FRAME;
      slot = p / DIV;
      es   = 2'(slot);
      ea   = ((p % DIV) >= GUARD && !m_latched[slot]) ? ~(4'b0001 << slot) : 4'hF;
      ef   = (m_t >= FRAME && p == 0);
    end
    checkOutput("model", es, ea, ef);
    checkInvariants();
  endtask

  // Scan with en=1 until the model sits at frame position pos.
  task automatic runUntil(input int pos, input int budget);
    int k = 0;
    while (!(m_active && (m_t % FRAME) == pos) && k < budget) begin
      applyStimulus(1'b0, 1'b1, cur_blank);
      k++;
    end
    vectors++;
    if (!(m_active && (m_t % FRAME) == pos)) begin
      miscompares++;
      $display("[TB] FAIL run_until cyc=%0d: got position %0d, expected %0d", cyc, m_t % FRAME, pos);
    end
  endtask

  initial begin
    rst   = 1'b1;
    en    = 1'b1;
    blank = 4'b0000;

    // reset for 3 cycles, then the opening of a normal scan
    tbl[0]  = '{1'b1, 1'b1, 4'b0000, 2'd0, 4'hF, 1'b0};
    tbl[1]  = '{1'b1, 1'b1, 4'b0000, 2'd0, 4'hF, 1'b0};
    tbl[2]  = '{1'b1, 1'b1, 4'b0000, 2'd0, 4'hF, 1'b0};
    tbl[3]  = '{1'b0, 1'b1, 4'b0000, 2'd0, 4'hF, 1'b0};
    tbl[4]  = '{1'b0, 1'b1, 4'b0000, 2'd0, 4'hF, 1'b0};
    tbl[5]  = '{1'b0, 1'b1, 4'b0000, 2'd0, 4'hE, 1'b0};
    tbl[6]  = '{1'b0, 1'b1, 4'b0000, 2'd0, 4'hE, 1'b0};
    tbl[7]  = '{1'b0, 1'b1, 4'b0000, 2'd0, 4'hE, 1'b0};
    tbl[8]  = '{1'b0, 1'b1, 4'b0000, 2'd0, 4'hE, 1'b0};
    tbl[9]  = '{1'b0, 1'b1, 4'b0000, 2'd0, 4'hE, 1'b0};
    tbl[10] = '{1'b0, 1'b1, 4'b0000, 2'd0, 4'hE, 1'b0};
    tbl[11] = '{1'b0, 1'b1, 4'b0000, 2'd1, 4'hF, 1'b0};
    tbl[12] = '{1'b0, 1'b1, 4'b0000, 2'd1, 4'hF, 1'b0};

    @(negedge clk);
    for (int i = 0; i < 13; i++) begin
      applyStimulus(tbl[i].rst, tbl[i].en, tbl[i].blank);
      checkOutput($sformatf("table[%0d]", i), tbl[i].sel, tbl[i].an, tbl[i].frame);
    end

    // normal scan: two more full frames, frame pulses at wrap
    for (int i = 0; i < 2 * FRAME; i++) applyStimulus(1'b0, 1'b1, cur_blank);
    runUntil(0, FRAME + 2);
    checkOutput("wrap_frame", 2'd0, 4'hF, 1'b1);
    runUntil(26, FRAME + 2);
    checkOutput("digit3_lit", 2'd3, 4'h7, 1'b0);

    // blank digit 2 only
    cur_blank = 4'b0100;
    runUntil(9, FRAME + 2);
    runUntil(18, FRAME + 2);
    checkOutput("digit2_blank", 2'd2, 4'hF, 1'b0);
    runUntil(26, FRAME + 2);
    checkOutput("digit3_unblanked", 2'd3, 4'h7, 1'b0);
    cur_blank = 4'b0000;

    // blank digit 0 midway through its lit part: this slot stays lit
    runUntil(5, FRAME + 2);
    cur_blank = 4'b0001;
    applyStimulus(1'b0, 1'b1, cur_blank);
    checkOutput("blank_mid_slot", 2'd0, 4'hE, 1'b0);
    runUntil(7, FRAME + 2);
    checkOutput("blank_mid_slot_end", 2'd0, 4'hE, 1'b0);
    runUntil(2, FRAME + 2);
    checkOutput("blank_next_slot0", 2'd0, 4'hF, 1'b0);
    cur_blank = 4'b0000;

    // disable at the 3rd lit cycle of digit 2, then re-enable
    runUntil(20, FRAME + 2);
    checkOutput("pre_disable", 2'd2, 4'hB, 1'b0);
    applyStimulus(1'b0, 1'b0, cur_blank);
    checkOutput("disabled", 2'd0, 4'hF, 1'b0);
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b0, cur_blank);
    checkOutput("disabled_hold", 2'd0, 4'hF, 1'b0);
    applyStimulus(1'b0, 1'b1, cur_blank);
    checkOutput("reenable_g0", 2'd0, 4'hF, 1'b0);
    applyStimulus(1'b0, 1'b1, cur_blank);
    checkOutput("reenable_g1", 2'd0, 4'hF, 1'b0);
    applyStimulus(1'b0, 1'b1, cur_blank);
    checkOutput("reenable_lit", 2'd0, 4'hE, 1'b0);

    // reset during the lit part of digit 3, then restart
    runUntil(27, FRAME + 2);
    applyStimulus(1'b1, 1'b1, cur_blank);
    checkOutput("mid_reset", 2'd0, 4'hF, 1'b0);
    applyStimulus(1'b0, 1'b1, cur_blank);
    checkOutput("restart_g0", 2'd0, 4'hF, 1'b0);
    applyStimulus(1'b0, 1'b1, cur_blank);
    checkOutput("restart_g1", 2'd0, 4'hF, 1'b0);
    applyStimulus(1'b0, 1'b1, cur_blank);
    checkOutput("restart_lit", 2'd0, 4'hE, 1'b0);
    for (int i = 0; i < FRAME; i++) applyStimulus(1'b0, 1'b1, cur_blank);

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      logic r;
      logic e;
      r = ($urandom_range(0, 299) == 0);
      e = ($urandom_range(0, 149) != 0);
      if ($urandom_range(0, 19) == 0) cur_blank = 4'($urandom_range(0, 15));
      applyStimulus(r, e, cur_blank);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
